// File: rtl/dmem_pkg.sv
// Shared types and helpers for the latency-controlled data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wait-counter width for a given read latency (LAT_CW = $clog2(RD_LAT)+1).
  function automatic int lat_cw(input int rd_lat);
    return $clog2(rd_lat) + 1;
  endfunction

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_lat_ctrl_if.sv
// Request/response bus between the CPU memory stage and the data memory.
interface dmem_lat_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W+1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage with byte-lane write port and registered read port.
// Contents are never reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read data captured at the accept edge; held until the next read
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dmem_lat_ctrl.sv
// Data memory with valid/ready handshake, configurable read latency and
// pipeline stall output.
// Optional feature: define DMEM_BYTE_LANES_EN to honour req_be on writes;
// otherwise every accepted aligned write stores the full word.
module dmem_lat_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  dmem_lat_ctrl_if.slave  bus
);
  localparam int NB     = DATA_W / 8;
  localparam int LAT_CW = lat_cw(RD_LAT);
  localparam logic [LAT_CW-1:0] CNT_INIT = LAT_CW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  state_e              state, state_d;
  logic [LAT_CW-1:0]   cnt, cnt_d;
  logic                ready, rsp_now;
  logic                acc, rd_acc, mis, wr_en;
  logic                err_w_q, rd_mis_q;
  logic [NB-1:0]       wr_be;
  logic [DATA_W-1:0]   arr_rdata;
  logic [ADDR_W-1:0]   idx;

  assign mis    = is_misaligned(bus.req_addr[1:0]);
  assign idx    = bus.req_addr[ADDR_W+1:2];
  // Reset dominates: nothing is accepted while rst is high.
  assign acc    = bus.req_valid & (state != WAIT) & ~rst;
  assign rd_acc = acc & ~bus.req_we;

`ifdef DMEM_BYTE_LANES_EN
  assign wr_be  = bus.req_be;
  assign wr_en  = acc & bus.req_we & ~mis & (|bus.req_be);
`else
  assign wr_be  = '1;
  assign wr_en  = acc & bus.req_we & ~mis;
`endif

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state, counter and handshake outputs
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ready   = rst | (state != WAIT);
    rsp_now = (state == RESP) & ~rst;
    unique case (state)
      IDLE, RESP: begin
        state_d = IDLE;
        if (rd_acc) begin
          if (RD_LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_d = RESP;
        else           cnt_d   = cnt - LAT_CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Misaligned-write error pulse and misaligned-read tag
  always_ff @(posedge clk) begin
    if (rst) begin
      err_w_q  <= 1'b0;
      rd_mis_q <= 1'b0;
    end else begin
      err_w_q <= acc & bus.req_we & mis;
      if (rd_acc) rd_mis_q <= mis;
    end
  end

  dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (wr_en),
    .be    (wr_be),
    .waddr (idx),
    .wdata (bus.req_wdata),
    .re    (rd_acc),
    .raddr (idx),
    .rdata (arr_rdata)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_now;
  assign bus.rsp_rdata = (rsp_now & ~rd_mis_q) ? arr_rdata : '0;
  assign bus.rsp_err   = ~rst & (err_w_q | ((state == RESP) & rd_mis_q));
  assign bus.stall     = bus.req_valid & ~ready;
endmodule
